// File: rtl/sopc_base_onchip_ram_pipe.sv
// Single-port on-chip RAM as an Avalon-MM slave: pipelined reads, waitrequest, post-reset clear.
// Optional per-byte parity storage and checking with SOPC_ONCHIP_RAM_PARITY_EN.
module sopc_base_onchip_ram_pipe #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned DEPTH          = 10000,
  parameter int unsigned ADDR_W         = 14,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned CLEAR_ON_RESET = 1,
  parameter string       INIT_FILE      = ""
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  input  logic                clken,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                waitrequest,
`ifdef SOPC_ONCHIP_RAM_PARITY_EN
  output logic                parity_err,
`endif
  output logic                init_busy
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef SOPC_ONCHIP_RAM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + NB;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [MEM_W-1:0]  mem [DEPTH];

  logic              clearing, in_range, accept, wr_acc, rd_acc;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [MEM_W-1:0]  mem_wword, mem_wmask, rd_word;
  logic [IDX_W-1:0]  widx, ridx;

  assign clearing    = (state_q == StClear);
  assign in_range    = (32'(address) < DEPTH);
  assign accept      = ~clearing & clken & chipselect & (read | write);
  assign wr_acc      = accept & write;
  assign rd_acc      = accept & read & ~write;
  assign init_busy   = clearing;
  assign waitrequest = ~reset_n | clearing | ~clken;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= (CLEAR_ON_RESET != 0) ? StClear : StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClear: begin
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun:   state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  // Clear engine and bus writes share the single write port; clear has priority.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = address;
    mem_wword = '0;
    mem_wmask = '0;
    if (clearing) begin
      mem_we    = reset_n;
      mem_waddr = cnt_q;
      mem_wmask = '1;
    end else if (wr_acc && in_range) begin
      mem_we = reset_n;
      for (int unsigned i = 0; i < NB; i++) begin
        mem_wword[i*8 +: 8] = writedata[i*8 +: 8];
        mem_wmask[i*8 +: 8] = {8{byteenable[i]}};
`ifdef SOPC_ONCHIP_RAM_PARITY_EN
        mem_wword[DATA_W+i] = ^writedata[i*8 +: 8];
        mem_wmask[DATA_W+i] = byteenable[i];
`endif
      end
    end
  end

  assign widx = mem_waddr[IDX_W-1:0];
  assign ridx = address[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[widx] <= (mem[widx] & ~mem_wmask) | (mem_wword & mem_wmask);
    end
  end

  assign rd_word = in_range ? mem[ridx] : '0;

  logic              v1_q, vo;
  logic [DATA_W-1:0] d1_q, dout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q <= 1'b0;
      d1_q <= '0;
    end else if (clken) begin
      v1_q <= rd_acc;
      if (rd_acc) d1_q <= rd_word[DATA_W-1:0];
    end
  end

`ifdef SOPC_ONCHIP_RAM_PARITY_EN
  logic rd_perr, p1_q, po;

  always_comb begin
    rd_perr = 1'b0;
    for (int unsigned i = 0; i < NB; i++) begin
      rd_perr |= (^rd_word[i*8 +: 8]) ^ rd_word[DATA_W+i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_q <= 1'b0;
    end else if (clken && rd_acc) begin
      p1_q <= rd_perr;
    end
  end
`endif

  if (READ_LATENCY >= 2) begin : g_lat2
    logic              v2_q;
    logic [DATA_W-1:0] d2_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else if (clken) begin
        v2_q <= v1_q;
        if (v1_q) d2_q <= d1_q;
      end
    end
    assign vo   = v2_q;
    assign dout = d2_q;

`ifdef SOPC_ONCHIP_RAM_PARITY_EN
    logic p2_q;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        p2_q <= 1'b0;
      end else if (clken && v1_q) begin
        p2_q <= p1_q;
      end
    end
    assign po = p2_q;
`endif
  end else begin : g_lat1
    assign vo   = v1_q;
    assign dout = d1_q;
`ifdef SOPC_ONCHIP_RAM_PARITY_EN
    assign po   = p1_q;
`endif
  end

  // A stalled cycle holds the pending valid back rather than dropping it.
  assign readdata      = dout;
  assign readdatavalid = vo & clken;
`ifdef SOPC_ONCHIP_RAM_PARITY_EN
  assign parity_err    = readdatavalid & po;
`endif

endmodule
